alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shared-ALU arbiter and initiator for the multiprocessor architecture. Accepts 8-bit logic-operation requests from up to N_CORES cores, grants one at a time by round-robin, drives operands and opcode into the shared combinational 8-bit logic unit (OR/AND/etc.), captures its result and returns it to the requesting core with a valid/ack handshake. It is the requesting side of the unit's operand/result interface.

## Interface
- N_CORES, 4: number of requesting cores (2..8).
- IDX_W, $clog2(N_CORES): width of grant index and round-robin pointer.
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- req_valid  input  N_CORES  per-core request; held until accepted.
- req_a  input  8*N_CORES  operand A, core i on bits [8i+7:8i].
- req_b  input  8*N_CORES  operand B, same packing.
- req_op  input  2*N_CORES  opcode, core i on bits [2i+1:2i]; passed through uninterpreted.
- req_ready  output  N_CORES  combinational one-hot accept; transfer when req_valid[i] & req_ready[i] at an edge.
- alu_a  output  8  registered operand A to shared logic unit.
- alu_b  output  8  registered operand B.
- alu_op  output  2  registered opcode.
- alu_result  input  8  combinational result from shared logic unit.
- resp_valid  output  N_CORES  registered one-hot; response for core i is valid.
- resp_data  output  8  registered result, meaningful while any resp_valid bit is high.
- resp_ack  input  N_CORES  core acknowledges its response.
- ops_done  output  16  count of completed (acked) operations, wraps 0xFFFF -> 0x0000.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: grant g = first index i, searching ptr, ptr+1, ..., ptr+N_CORES-1 (mod N_CORES), with req_valid[i]=1. req_ready = one-hot(g) if any request, else 0. On transfer edge: alu_a/alu_b/alu_op <= core g's fields, latch g, -> EXEC. No request: stay IDLE.
- EXEC: req_ready = 0. Next edge: resp_data <= alu_result, resp_valid <= one-hot(g), -> RESP.
- RESP: req_ready = 0. Edge with resp_ack[g]=1: resp_valid <= 0, ptr <= (g+1) mod N_CORES, ops_done <= ops_done+1, -> IDLE. resp_ack bits of other cores ignored. resp_data, alu_a/b/op hold.
- Requests arriving during EXEC/RESP wait; never dropped by this block (cores hold req_valid).
- Round-robin: core just served has lowest priority next arbitration; no starvation with N_CORES requesters continuously active.
- Reset: state IDLE, ptr 0, alu_a/alu_b/alu_op 0, resp_data 0x00, resp_valid 0, ops_done 0; req_ready follows IDLE rule from the first post-reset cycle. Reset mid-EXEC/RESP abandons the operation: no response delivered, ops_done not incremented.

## Timing
- Request cycle C (IDLE, transfer at end of C): alu_a/b/op valid in C+1; resp_valid/resp_data visible in C+2.
- Minimum 3 cycles per operation (IDLE, EXEC, RESP with ack in first RESP cycle); one operation in flight.
- resp_ack sampled only in RESP; ack held high across the transition has no effect in IDLE.
- alu_result sampled only at the EXEC->RESP edge; shared unit must settle within one cycle.
- ops_done updates on the same edge resp_valid falls.

## Test plan
- Single request: core 1, a=0xA5, b=0x0F, op=0 (bench unit models OR) -> req_ready=0b0010 in request cycle, alu_a=0xA5/alu_b=0x0F next cycle, resp_valid=0b0010 with resp_data=0xAF two cycles after; ack -> resp_valid=0, ops_done=1.
- Round-robin: all four cores request continuously after reset -> grant order 0,1,2,3,0; core i returns i-th expected result each time.
- Delayed ack: core 2 response held 5 cycles without ack while core 0 requests -> resp_valid/resp_data stable, req_ready=0 throughout; core 0 granted in cycle after ack.
- Wrong ack: in RESP for core 3, resp_ack=0b0001 -> no state change; resp_ack=0b1000 then completes.
- Reset in EXEC (core 0, a=0xFF, b=0x00) -> all outputs reset values next cycle, no resp_valid ever for that op, ops_done=0, ptr=0.
- Counter wrap: preload 65535 completed ops via fast stimulus (or force) -> next ack gives ops_done=0x0000.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - core request/response and shared logic-unit bus for alu_arbiter
interface alu_arbiter_if #(
    parameter int N_CORES = 4
);
    logic [N_CORES-1:0]   req_valid;
    logic [N_CORES-1:0]   req_ready;
    logic [8*N_CORES-1:0] req_a;
    logic [8*N_CORES-1:0] req_b;
    logic [2*N_CORES-1:0] req_op;
    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic [1:0]           alu_op;
    logic [7:0]           alu_result;
    logic [N_CORES-1:0]   resp_valid;
    logic [7:0]           resp_data;
    logic [N_CORES-1:0]   resp_ack;
    logic [15:0]          ops_done;

    // master is the arbiter; slave is the cores plus the shared logic unit
    modport master (
        input  req_valid, req_a, req_b, req_op, alu_result, resp_ack,
        output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data, ops_done
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, alu_result, resp_ack,
        input  req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data, ops_done
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter and initiator for a shared 8-bit logic unit
module alu_arbiter #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = $clog2(N_CORES)
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [7:0]         alu_a_q, alu_a_d;
    logic [7:0]         alu_b_q, alu_b_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic [7:0]         resp_data_q, resp_data_d;
    logic [N_CORES-1:0] resp_valid_q, resp_valid_d;
    logic [15:0]        ops_done_q, ops_done_d;

    logic               any_req;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [N_CORES-1:0] grant_oh;
    logic [N_CORES-1:0] cur_oh;
    logic [7:0]         sel_a;
    logic [7:0]         sel_b;
    logic [1:0]         sel_op;
    logic [N_CORES-1:0] ready;

    // Walk from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        any_req   = |bus.req_valid;
        grant_idx = '0;
        cand      = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % N_CORES);
            if (bus.req_valid[cand]) grant_idx = cand;
        end
    end

    always_comb begin
        grant_oh = '0;
        cur_oh   = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_op   = '0;
        for (int i = 0; i < N_CORES; i++) begin
            grant_oh[i] = (grant_idx == IDX_W'(i));
            cur_oh[i]   = (gidx_q == IDX_W'(i));
            if (grant_idx == IDX_W'(i)) begin
                sel_a  = bus.req_a[8*i +: 8];
                sel_b  = bus.req_b[8*i +: 8];
                sel_op = bus.req_op[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gidx_d       = gidx_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        ops_done_d   = ops_done_q;
        ready        = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    ready    = grant_oh;
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    alu_op_d = sel_op;
                    gidx_d   = grant_idx;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_data_d  = bus.alu_result;
                resp_valid_d = cur_oh;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                // Only the granted core's ack completes the operation.
                if (bus.resp_ack[gidx_q]) begin
                    resp_valid_d = '0;
                    ptr_d        = (gidx_q == IDX_W'(N_CORES - 1)) ? '0 : gidx_q + IDX_W'(1);
                    ops_done_d   = ops_done_q + 16'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gidx_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= '0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gidx_q       <= gidx_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.ops_done   = ops_done_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.N_CORES(N)) bus();
    alu_arbiter #(.N_CORES(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fa [N];
    logic [7:0] fb [N];
    logic [1:0] fo [N];

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        fa[i] = a; fb[i] = b; fo[i] = op;
        bus.req_a[8*i +: 8]  = a;
        bus.req_b[8*i +: 8]  = b;
        bus.req_op[2*i +: 2] = op;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        bus.req_valid = '0;
        bus.resp_ack  = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (bus.alu_a !== 8'h00) $display("FAIL reset_alu_a got %h want 00", bus.alu_a); else n_pass++;
        n_checks++; if (bus.alu_b !== 8'h00) $display("FAIL reset_alu_b got %h want 00", bus.alu_b); else n_pass++;
        n_checks++; if (bus.alu_op !== 2'd0) $display("FAIL reset_alu_op got %h want 0", bus.alu_op); else n_pass++;
        n_checks++; if (bus.resp_valid !== 4'b0000) $display("FAIL reset_resp_valid got %b want 0000", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.resp_data !== 8'h00) $display("FAIL reset_resp_data got %h want 00", bus.resp_data); else n_pass++;
        n_checks++; if (bus.ops_done !== 16'h0000) $display("FAIL reset_ops_done got %h want 0000", bus.ops_done); else n_pass++;
        n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready_idle got %b want 0000", bus.req_ready); else n_pass++;
        bus.req_valid = 4'b1111;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL reset_ptr_grant got %b want 0001", bus.req_ready); else n_pass++;
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        set_req(1, 8'hA5, 8'h0F, 2'd0);
        bus.req_valid = 4'b0010;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL single_ready got %b want 0010", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 4'b0000;
        #1;
        n_checks++; if (bus.alu_a !== 8'hA5) $display("FAIL single_alu_a got %h want a5", bus.alu_a); else n_pass++;
        n_checks++; if (bus.alu_b !== 8'h0F) $display("FAIL single_alu_b got %h want 0f", bus.alu_b); else n_pass++;
        n_checks++; if (bus.resp_valid !== 4'b0000) $display("FAIL single_exec_resp got %b want 0000", bus.resp_valid); else n_pass++;
        step();
        #1;
        n_checks++; if (bus.resp_valid !== 4'b0010) $display("FAIL single_resp_valid got %b want 0010", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.resp_data !== 8'hAF) $display("FAIL single_resp_data got %h want af", bus.resp_data); else n_pass++;
        bus.resp_ack = 4'b0010;
        step();
        bus.resp_ack = 4'b0000;
        #1;
        n_checks++; if (bus.resp_valid !== 4'b0000) $display("FAIL single_resp_clear got %b want 0000", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.ops_done !== 16'd1) $display("FAIL single_ops_done got %0d want 1", bus.ops_done); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0]  oh;
        logic [7:0]  exp;
        int          g;
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g   = k % N;
            oh  = 4'(1 << g);
            exp = ref_alu(fa[g], fb[g], fo[g]);
            #1;
            n_checks++; if (bus.req_ready !== oh) $display("FAIL rr_grant[%0d] got %b want %b", k, bus.req_ready, oh); else n_pass++;
            step();
            step();
            #1;
            n_checks++; if (bus.resp_valid !== oh) $display("FAIL rr_resp_valid[%0d] got %b want %b", k, bus.resp_valid, oh); else n_pass++;
            n_checks++; if (bus.resp_data !== exp) $display("FAIL rr_resp_data[%0d] got %h want %h", k, bus.resp_data, exp); else n_pass++;
            bus.resp_ack = oh;
            step();
            bus.resp_ack = 4'b0000;
        end
        bus.req_valid = 4'b0000;
        #1;
        n_checks++; if (bus.ops_done !== 16'd5) $display("FAIL rr_ops_done got %0d want 5", bus.ops_done); else n_pass++;
    endtask

    task automatic test_delayed_ack();
        logic [7:0] exp;
        do_reset();
        set_req(2, 8'h3C, 8'h5A, 2'd2);
        exp = ref_alu(8'h3C, 8'h5A, 2'd2);
        bus.req_valid = 4'b0100;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) $display("FAIL dly_grant got %b want 0100", bus.req_ready); else n_pass++;
        step();
        set_req(0, 8'h81, 8'h7E, 2'd1);
        bus.req_valid = 4'b0001;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL dly_exec_ready got %b want 0000", bus.req_ready); else n_pass++;
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (bus.resp_valid !== 4'b0100) $display("FAIL dly_resp_valid[%0d] got %b want 0100", c, bus.resp_valid); else n_pass++;
            n_checks++; if (bus.resp_data !== exp) $display("FAIL dly_resp_data[%0d] got %h want %h", c, bus.resp_data, exp); else n_pass++;
            n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL dly_ready[%0d] got %b want 0000", c, bus.req_ready); else n_pass++;
            step();
        end
        bus.resp_ack = 4'b0100;
        step();
        bus.resp_ack = 4'b0000;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL dly_next_grant got %b want 0001", bus.req_ready); else n_pass++;
        n_checks++; if (bus.ops_done !== 16'd1) $display("FAIL dly_ops_done got %0d want 1", bus.ops_done); else n_pass++;
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_wrong_ack();
        do_reset();
        set_req(3, 8'hC3, 8'h18, 2'd0);
        bus.req_valid = 4'b1000;
        step();
        bus.req_valid = 4'b0000;
        step();
        bus.resp_ack = 4'b0001;
        step();
        bus.resp_ack = 4'b0111;
        #1;
        n_checks++; if (bus.resp_valid !== 4'b1000) $display("FAIL wack_hold1 got %b want 1000", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.ops_done !== 16'd0) $display("FAIL wack_ops1 got %0d want 0", bus.ops_done); else n_pass++;
        step();
        #1;
        n_checks++; if (bus.resp_valid !== 4'b1000) $display("FAIL wack_hold2 got %b want 1000", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.resp_data !== 8'hDB) $display("FAIL wack_data got %h want db", bus.resp_data); else n_pass++;
        bus.resp_ack = 4'b1000;
        step();
        bus.resp_ack = 4'b0000;
        #1;
        n_checks++; if (bus.resp_valid !== 4'b0000) $display("FAIL wack_done got %b want 0000", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.ops_done !== 16'd1) $display("FAIL wack_ops2 got %0d want 1", bus.ops_done); else n_pass++;
    endtask

    task automatic test_reset_in_exec();
        do_reset();
        set_req(2, 8'h12, 8'h34, 2'd0);
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0000;
        step();
        bus.resp_ack = 4'b0100;
        step();
        bus.resp_ack = 4'b0000;
        set_req(0, 8'hFF, 8'h00, 2'd0);
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (bus.alu_a !== 8'h00) $display("FAIL rexec_alu_a got %h want 00", bus.alu_a); else n_pass++;
        n_checks++; if (bus.resp_valid !== 4'b0000) $display("FAIL rexec_resp_valid got %b want 0000", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.ops_done !== 16'd0) $display("FAIL rexec_ops_done got %0d want 0", bus.ops_done); else n_pass++;
        bus.req_valid = 4'b1110;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL rexec_ptr got %b want 0010", bus.req_ready); else n_pass++;
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            n_checks++; if (bus.resp_valid !== 4'b0000) $display("FAIL rexec_no_resp[%0d] got %b want 0000", c, bus.resp_valid); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit         pend [N];
        bit         wait_resp [N];
        int         phase;
        int         m_g;
        int         m_ptr;
        int         g;
        logic [7:0] m_exp;
        logic [15:0] m_done;
        logic [3:0] exp_ready;
        logic [3:0] vbits;
        do_reset();
        phase = 0; m_g = 0; m_ptr = 0; m_exp = '0; m_done = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; wait_resp[i] = 0; end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && !wait_resp[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    set_req(i, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
                end
            end
            vbits = '0;
            for (int i = 0; i < N; i++) vbits[i] = pend[i];
            bus.req_valid = vbits;
            bus.resp_ack  = 4'($urandom);
            if (phase == 2) begin
                if ($urandom_range(0, 2) == 0) bus.resp_ack[m_g] = 1'b1;
                else bus.resp_ack[m_g] = 1'b0;
            end
            exp_ready = '0;
            g = -1;
            if (phase == 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                if (g >= 0) exp_ready = 4'(1 << g);
            end
            #1;
            n_checks++; if (bus.req_ready !== exp_ready) $display("FAIL rnd_ready@%0d got %b want %b", cyc, bus.req_ready, exp_ready); else n_pass++;
            if (phase == 2) begin
                n_checks++; if (bus.resp_valid !== 4'(1 << m_g)) $display("FAIL rnd_resp_valid@%0d got %b want %b", cyc, bus.resp_valid, 4'(1 << m_g)); else n_pass++;
                n_checks++; if (bus.resp_data !== m_exp) $display("FAIL rnd_resp_data@%0d got %h want %h", cyc, bus.resp_data, m_exp); else n_pass++;
            end else begin
                n_checks++; if (bus.resp_valid !== 4'b0000) $display("FAIL rnd_resp_idle@%0d got %b want 0000", cyc, bus.resp_valid); else n_pass++;
            end
            n_checks++; if (bus.ops_done !== m_done) $display("FAIL rnd_ops_done@%0d got %0d want %0d", cyc, bus.ops_done, m_done); else n_pass++;
            if (phase == 0 && g >= 0) begin
                m_g = g;
                m_exp = ref_alu(fa[g], fb[g], fo[g]);
                pend[g] = 0;
                wait_resp[g] = 1;
                phase = 1;
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2 && bus.resp_ack[m_g]) begin
                phase = 0;
                m_ptr = (m_g + 1) % N;
                m_done = m_done + 16'd1;
                wait_resp[m_g] = 0;
            end
            step();
        end
        bus.req_valid = '0;
        bus.resp_ack  = '0;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        force dut.ops_done_q = 16'hFFFF;
        step();
        release dut.ops_done_q;
        #1;
        n_checks++; if (bus.ops_done !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", bus.ops_done); else n_pass++;
        set_req(1, 8'h01, 8'h02, 2'd0);
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b0000;
        step();
        bus.resp_ack = 4'b0010;
        step();
        bus.resp_ack = 4'b0000;
        #1;
        n_checks++; if (bus.ops_done !== 16'h0000) $display("FAIL wrap_ops_done got %h want 0000", bus.ops_done); else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.resp_ack  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_delayed_ack();
        test_wrong_ack();
        test_reset_in_exec();
        test_random();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
